// File: rtl/bram_run_scheduler_pkg.sv
// Shared definitions for the BRAM run scheduler: FSM encoding, requester IDs
// and the default run-count width used by the accessor.
package bram_sched_pkg;

  localparam int CNT_BIT_DEFAULT = 31;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = S_IDLE,
    LAUNCH    = S_LAUNCH,
    WAIT_DONE = S_WAIT,
    RESP      = S_RESP
  } state_t;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

endpackage

// File: rtl/bram_run_scheduler_if.sv
// Bundle of requester, response and accessor-facing signals of the scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface bram_run_scheduler_if #(
  parameter int CNT_BIT = 31
);

  logic               req0_valid_i;
  logic [CNT_BIT-1:0] req0_count_i;
  logic               req0_ready_o;
  logic               req1_valid_i;
  logic [CNT_BIT-1:0] req1_count_i;
  logic               req1_ready_o;
  logic               resp_valid_o;
  logic               resp_id_o;
  logic               resp_timeout_o;
  logic               busy_o;
  logic               start_run_o;
  logic [CNT_BIT-1:0] run_count_o;
  logic               acc_idle_i;
  logic               acc_done_i;

  modport slave (
    input  req0_valid_i, req0_count_i, req1_valid_i, req1_count_i,
    input  acc_idle_i, acc_done_i,
    output req0_ready_o, req1_ready_o,
    output resp_valid_o, resp_id_o, resp_timeout_o, busy_o,
    output start_run_o, run_count_o
  );

  modport master (
    output req0_valid_i, req0_count_i, req1_valid_i, req1_count_i,
    output acc_idle_i, acc_done_i,
    input  req0_ready_o, req1_ready_o,
    input  resp_valid_o, resp_id_o, resp_timeout_o, busy_o,
    input  start_run_o, run_count_o
  );

endinterface

// File: rtl/bram_run_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. With both requests present the requester that
// did not win last time is chosen; last_grant starts at 1 so req0 wins first.
module rr_arb2
  import bram_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant
);

  logic last_grant;

  // Pick the requester to offer ready to this cycle
  always_comb begin
    grant = REQ0_ID;
    if (req == 2'b11)
      grant = ~last_grant;
    else if (req[1])
      grant = REQ1_ID;
  end

  // Remember who won, but only once the handshake actually happens
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= REQ1_ID;
    else if (accept)
      last_grant <= grant;
  end

endmodule

// File: rtl/bram_run_scheduler.sv
// Front-end controller for BRAM_accessor: arbitrates host and DMA requests,
// launches one run at a time, waits for done (or a watchdog timeout) and
// returns a one-cycle tagged completion response.
module bram_run_scheduler
  import bram_sched_pkg::*;
#(
  parameter int               CNT_BIT  = CNT_BIT_DEFAULT,
  parameter int               WD_BIT   = 16,
  parameter logic [WD_BIT-1:0] WD_LIMIT = 16'd1000
) (
  input  logic              clk,
  input  logic              reset,
  bram_run_scheduler_if.slave bus
);

  state_t             state;
  state_t             next_state;
  logic               grant;
  logic               ready0;
  logic               ready1;
  logic               accept;
  logic [CNT_BIT-1:0] grant_count;
  logic [CNT_BIT-1:0] count_q;
  logic               id_q;
  logic               timeout_q;
  logic [WD_BIT-1:0]  wd;
  logic               wd_expired;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({bus.req1_valid_i, bus.req0_valid_i}),
    .accept (accept),
    .grant  (grant)
  );

  // Handshake: only one ready can be high since it is qualified by the grant
  always_comb begin
    ready0      = (state == IDLE) & bus.acc_idle_i & bus.req0_valid_i & (grant == REQ0_ID);
    ready1      = (state == IDLE) & bus.acc_idle_i & bus.req1_valid_i & (grant == REQ1_ID);
    accept      = ready0 | ready1;
    grant_count = (grant == REQ1_ID) ? bus.req1_count_i : bus.req0_count_i;
    wd_expired  = (wd == WD_LIMIT - 1'b1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic; a zero-length run skips the accessor entirely
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = (grant_count == '0) ? RESP : LAUNCH;
      LAUNCH:    next_state = WAIT_DONE;
      WAIT_DONE: if (bus.acc_done_i || wd_expired) next_state = RESP;
      RESP:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Run context and watchdog; done beats a coincident watchdog terminal count
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      id_q      <= REQ0_ID;
      timeout_q <= 1'b0;
      wd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count_q   <= grant_count;
            id_q      <= grant;
            timeout_q <= 1'b0;
          end
        end
        LAUNCH: wd <= '0;
        WAIT_DONE: begin
          wd <= wd + 1'b1;
          if (!bus.acc_done_i && wd_expired)
            timeout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; response fields are zero outside RESP
  always_comb begin
    bus.req0_ready_o   = ready0;
    bus.req1_ready_o   = ready1;
    bus.start_run_o    = (state == LAUNCH);
    bus.run_count_o    = count_q;
    bus.resp_valid_o   = (state == RESP);
    bus.resp_id_o      = (state == RESP) & id_q;
    bus.resp_timeout_o = (state == RESP) & timeout_q;
    bus.busy_o         = (state != IDLE);
  end

endmodule

// File: tb/tb_bram_run_scheduler.sv
// Directed testbench for bram_run_scheduler: single run, round-robin
// contention, zero-length run, watchdog timeout, done/timeout tie and reset
// in the middle of a run.
module tb_bram_run_scheduler;

  localparam int CNT_BIT = 31;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bram_run_scheduler_if #(.CNT_BIT(CNT_BIT)) bus ();

  bram_run_scheduler #(
    .CNT_BIT  (CNT_BIT),
    .WD_BIT   (16),
    .WD_LIMIT (16'd1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both requester ports and let combinational outputs settle
  task automatic applyStimulus(input logic v0, input int c0, input logic v1, input int c1);
    bus.req0_valid_i = v0;
    bus.req0_count_i = c0[CNT_BIT-1:0];
    bus.req1_valid_i = v1;
    bus.req1_count_i = c1[CNT_BIT-1:0];
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Directed sequence
  initial begin
    logic exp_id;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.acc_idle_i = 1'b1;
    bus.acc_done_i = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 0);
    repeat (3) tick();

    checkOutput("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("rst_start", {31'd0, bus.start_run_o}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    checkOutput("rst_resp_id", {31'd0, bus.resp_id_o}, 32'd0);
    checkOutput("rst_resp_timeout", {31'd0, bus.resp_timeout_o}, 32'd0);
    checkOutput("rst_run_count", {1'b0, bus.run_count_o}, 32'd0);
    reset = 1'b0;
    tick();

    // Single request from req0, done 100 cycles after start
    $display("[TB] single request");
    applyStimulus(1'b1, 100, 1'b0, 0);
    checkOutput("t1_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
    checkOutput("t1_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
    checkOutput("t1_start_before", {31'd0, bus.start_run_o}, 32'd0);
    tick();
    bus.acc_idle_i = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 0);
    checkOutput("t1_start", {31'd0, bus.start_run_o}, 32'd1);
    checkOutput("t1_run_count", {1'b0, bus.run_count_o}, 32'd100);
    tick();
    for (int i = 0; i < 99; i++) begin
      checkOutput("t1_start_once", {31'd0, bus.start_run_o}, 32'd0);
      checkOutput("t1_no_early_resp", {31'd0, bus.resp_valid_o}, 32'd0);
      tick();
    end
    bus.acc_done_i = 1'b1;
    tick();
    bus.acc_done_i = 1'b0;
    bus.acc_idle_i = 1'b1;
    #1;
    checkOutput("t1_resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
    checkOutput("t1_resp_id", {31'd0, bus.resp_id_o}, 32'd0);
    checkOutput("t1_resp_timeout", {31'd0, bus.resp_timeout_o}, 32'd0);
    checkOutput("t1_run_count_held", {1'b0, bus.run_count_o}, 32'd100);
    tick();
    checkOutput("t1_resp_pulse", {31'd0, bus.resp_valid_o}, 32'd0);
    checkOutput("t1_idle", {31'd0, bus.busy_o}, 32'd0);

    // Contention after reset: grants alternate 0,1,0,1
    $display("[TB] contention");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 5, 1'b1, 7);
    for (int r = 0; r < 4; r++) begin
      exp_id = r[0];
      checkOutput("t2_ready0", {31'd0, bus.req0_ready_o}, {31'd0, ~exp_id});
      checkOutput("t2_ready1", {31'd0, bus.req1_ready_o}, {31'd0, exp_id});
      tick();
      checkOutput("t2_start", {31'd0, bus.start_run_o}, 32'd1);
      checkOutput("t2_run_count", {1'b0, bus.run_count_o}, exp_id ? 32'd7 : 32'd5);
      tick();
      bus.acc_done_i = 1'b1;
      #1;
      checkOutput("t2_wait_busy", {31'd0, bus.busy_o}, 32'd1);
      tick();
      bus.acc_done_i = 1'b0;
      #1;
      checkOutput("t2_resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
      checkOutput("t2_resp_id", {31'd0, bus.resp_id_o}, {31'd0, exp_id});
      tick();
    end
    applyStimulus(1'b0, 0, 1'b0, 0);

    // Zero-length run from req1 never starts the accessor
    $display("[TB] zero count");
    applyStimulus(1'b0, 0, 1'b1, 0);
    checkOutput("t3_ready1", {31'd0, bus.req1_ready_o}, 32'd1);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 0);
    checkOutput("t3_no_start", {31'd0, bus.start_run_o}, 32'd0);
    checkOutput("t3_resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
    checkOutput("t3_resp_id", {31'd0, bus.resp_id_o}, 32'd1);
    checkOutput("t3_resp_timeout", {31'd0, bus.resp_timeout_o}, 32'd0);
    tick();
    checkOutput("t3_no_start_after", {31'd0, bus.start_run_o}, 32'd0);
    checkOutput("t3_resp_pulse", {31'd0, bus.resp_valid_o}, 32'd0);

    // Watchdog: accessor never finishes
    $display("[TB] watchdog");
    applyStimulus(1'b1, 3, 1'b0, 0);
    checkOutput("t4_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
    tick();
    bus.acc_idle_i = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 0);
    checkOutput("t4_start", {31'd0, bus.start_run_o}, 32'd1);
    tick();
    for (int i = 0; i < 999; i++) begin
      checkOutput("t4_no_early_resp", {31'd0, bus.resp_valid_o}, 32'd0);
      tick();
    end
    checkOutput("t4_still_waiting", {31'd0, bus.busy_o}, 32'd1);
    checkOutput("t4_no_resp_999", {31'd0, bus.resp_valid_o}, 32'd0);
    tick();
    checkOutput("t4_resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
    checkOutput("t4_resp_timeout", {31'd0, bus.resp_timeout_o}, 32'd1);
    checkOutput("t4_resp_id", {31'd0, bus.resp_id_o}, 32'd0);
    tick();
    applyStimulus(1'b0, 0, 1'b1, 0);
    checkOutput("t4_hung_ready_a", {31'd0, bus.req1_ready_o}, 32'd0);
    tick();
    checkOutput("t4_hung_ready_b", {31'd0, bus.req1_ready_o}, 32'd0);
    checkOutput("t4_hung_idle", {31'd0, bus.busy_o}, 32'd0);
    tick();
    bus.acc_idle_i = 1'b1;
    applyStimulus(1'b0, 0, 1'b1, 0);
    checkOutput("t4_ready_after_idle", {31'd0, bus.req1_ready_o}, 32'd1);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 0);
    checkOutput("t4_followup_resp", {31'd0, bus.resp_valid_o}, 32'd1);
    checkOutput("t4_followup_id", {31'd0, bus.resp_id_o}, 32'd1);
    checkOutput("t4_followup_timeout", {31'd0, bus.resp_timeout_o}, 32'd0);
    tick();

    // Done arrives in the same cycle as the watchdog terminal count
    $display("[TB] done vs watchdog tie");
    applyStimulus(1'b1, 9, 1'b0, 0);
    checkOutput("t5_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
    tick();
    bus.acc_idle_i = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 0);
    tick();
    repeat (999) tick();
    bus.acc_done_i = 1'b1;
    tick();
    bus.acc_done_i = 1'b0;
    bus.acc_idle_i = 1'b1;
    #1;
    checkOutput("t5_resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
    checkOutput("t5_resp_timeout", {31'd0, bus.resp_timeout_o}, 32'd0);
    tick();

    // Reset during WAIT_DONE drops the run and restores req0 priority
    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 4, 1'b0, 0);
    tick();
    bus.acc_idle_i = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 0);
    tick();
    repeat (5) tick();
    checkOutput("t6_busy_before", {31'd0, bus.busy_o}, 32'd1);
    bus.acc_done_i = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.acc_done_i = 1'b0;
    #1;
    checkOutput("t6_busy_after", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("t6_no_resp", {31'd0, bus.resp_valid_o}, 32'd0);
    tick();
    checkOutput("t6_no_resp_later", {31'd0, bus.resp_valid_o}, 32'd0);
    bus.acc_idle_i = 1'b1;
    applyStimulus(1'b1, 2, 1'b1, 6);
    checkOutput("t6_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
    checkOutput("t6_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 0);
    checkOutput("t6_run_count", {1'b0, bus.run_count_o}, 32'd2);
    tick();
    bus.acc_done_i = 1'b1;
    tick();
    bus.acc_done_i = 1'b0;
    #1;
    checkOutput("t6_resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
    checkOutput("t6_resp_id", {31'd0, bus.resp_id_o}, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
